flex_down_counter: RTL



---
 rtl/flex_down_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/flex_down_counter.sv
// Loadable down-counter with zero flag, one-cycle expiry pulse and optional auto-reload.
// Every output is registered; clear beats load, and load beats count_enable.
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    zero_flag,
  output logic                    expired,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state;
  state_t                  state_next;
  logic [NUM_CNT_BITS-1:0] reload_reg;
  logic [NUM_CNT_BITS-1:0] reload_next;
  logic [NUM_CNT_BITS-1:0] count_next;
  logic                    zero_next;
  logic                    expired_next;
  logic                    busy_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      reload_reg <= CNT_ZERO;
      count_out  <= CNT_ZERO;
      zero_flag  <= 1'b0;
      expired    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      reload_reg <= reload_next;
      count_out  <= count_next;
      zero_flag  <= zero_next;
      expired    <= expired_next;
      busy       <= busy_next;
    end
  end

  // Reaching zero only raises the flags; the stop-or-reload decision waits for
  // the next enabled cycle, so an auto-reload period is reload value + 1.
  always_comb begin
    state_next   = state;
    reload_next  = reload_reg;
    count_next   = count_out;
    zero_next    = zero_flag;
    expired_next = 1'b0;

    if (clear) begin
      state_next  = IDLE;
      reload_next = CNT_ZERO;
      count_next  = CNT_ZERO;
      zero_next   = 1'b0;
    end else if (load) begin
      reload_next = load_val;
      count_next  = load_val;
      if (load_val != CNT_ZERO) begin
        state_next = RUN;
        zero_next  = 1'b0;
      end else begin
        state_next = DONE;
        zero_next  = 1'b1;
      end
    end else if ((state == RUN) && count_enable) begin
      if (count_out > CNT_ONE) begin
        count_next = count_out - CNT_ONE;
      end else if (count_out == CNT_ONE) begin
        count_next   = CNT_ZERO;
        zero_next    = 1'b1;
        expired_next = 1'b1;
      end else if (auto_reload) begin
        count_next = reload_reg;
        zero_next  = 1'b0;
      end else begin
        state_next = DONE;
      end
    end

    busy_next = (state_next == RUN);
  end

endmodule
